// File: rtl/fetch_unit_pkg.sv
// Constants shared by the fetch stage and the control block: next-PC selects, NOP word, fetch FSM states.
// No logic of its own, so no latency.
// No backpressure; declarations only.
package fetch_unit_pkg;

    localparam logic [2:0] PC_NEXT_SEL_STALL       = 3'd0;
    localparam logic [2:0] PC_NEXT_SEL_NEXT        = 3'd1;
    localparam logic [2:0] PC_NEXT_SEL_PC_IMM      = 3'd2;
    localparam logic [2:0] PC_NEXT_SEL_RS1_IMM     = 3'd3;
    localparam logic [2:0] PC_NEXT_SEL_COND_PC_IMM = 3'd4;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_TRAP  = 3'd4
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC target computation from the control block's select, offset and instruction size.
// Purely combinational, zero cycles.
// No backpressure; STALL and unused selects report take=0 and leave the PC alone.
module fetch_unit_pc_next_calc
    import fetch_unit_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] pc,
    input  logic [31:0] off,
    input  logic [2:0]  isize,
    input  logic [31:0] rs1,
    input  logic        cond,
    output logic        take,
    output logic [31:0] target,
    output logic        misalign
);

    logic [31:0] seq_target;
    logic [31:0] pc_rel_target;
    logic [31:0] rs1_rel_target;

    assign seq_target     = pc + {29'd0, isize};
    assign pc_rel_target  = pc + off;
    // Register-relative jumps drop bit 0 before the alignment check
    assign rs1_rel_target = (rs1 + off) & ~32'd1;

    always_comb begin
        take   = 1'b0;
        target = pc;
        case (sel)
            PC_NEXT_SEL_NEXT: begin
                take   = 1'b1;
                target = seq_target;
            end
            PC_NEXT_SEL_PC_IMM: begin
                take   = 1'b1;
                target = pc_rel_target;
            end
            PC_NEXT_SEL_RS1_IMM: begin
                take   = 1'b1;
                target = rs1_rel_target;
            end
            PC_NEXT_SEL_COND_PC_IMM: begin
                take   = 1'b1;
                target = cond ? pc_rel_target : seq_target;
            end
            default: begin
                take   = 1'b0;
                target = pc;
            end
        endcase
    end

    assign misalign = take & ~is_word_aligned(target);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem read at a time, holds the word for decode.
// Best case 3 cycles per instruction (REQ, WAIT, EXEC); +1 per ready-low or rvalid-delay cycle.
// Address held stable while imem_ready_i is low; decode stalls the stage via PC_NEXT_SEL_STALL.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  pc_next_sel_i,
    input  logic [31:0] pc_next_off_i,
    input  logic [2:0]  pc_isize_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] alu_res_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_data_o,
    output logic        instr_valid_o,
    output logic        misalign_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  data_q, data_d;
    logic         misalign_q, misalign_d;

    logic         calc_take;
    logic [31:0]  calc_target;
    logic         calc_misalign;

    // Only the branch condition bit of the ALU result matters here
    logic unused_alu_bits;
    assign unused_alu_bits = ^alu_res_i[31:1];

    fetch_unit_pc_next_calc u_pc_next_calc (
        .sel      (pc_next_sel_i),
        .pc       (pc_q),
        .off      (pc_next_off_i),
        .isize    (pc_isize_i),
        .rs1      (rs1_data_i),
        .cond     (alu_res_i[0]),
        .take     (calc_take),
        .target   (calc_target),
        .misalign (calc_misalign)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        data_d     = data_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_RESET: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    data_d  = imem_rdata_i;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (calc_take) begin
                    data_d = NOP_INSN;
                    if (calc_misalign) begin
                        misalign_d = 1'b1;
                        state_d    = ST_TRAP;
                    end else begin
                        pc_d    = calc_target;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RESET;
            pc_q       <= RESET_PC;
            data_q     <= NOP_INSN;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            data_q     <= data_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req_o    = (state_q == ST_REQ);
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign pc_data_o     = data_q;
    assign instr_valid_o = (state_q == ST_EXEC);
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/branch/jump targets, stalls, misalign trap, reset mid-fetch.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  pc_next_sel_i;
    logic [31:0] pc_next_off_i;
    logic [2:0]  pc_isize_i;
    logic [31:0] rs1_data_i;
    logic [31:0] alu_res_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] pc_data_o;
    logic        instr_valid_o;
    logic        misalign_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_next_sel_i (pc_next_sel_i),
        .pc_next_off_i (pc_next_off_i),
        .pc_isize_i    (pc_isize_i),
        .rs1_data_i    (rs1_data_i),
        .alu_res_i     (alu_res_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .pc_data_o     (pc_data_o),
        .instr_valid_o (instr_valid_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // From REQ: accept the request, then return data the next cycle; ends in EXEC
    task automatic do_fetch(input logic [31:0] word);
        imem_ready_i = 1'b1;
        step();
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word;
        step();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
    endtask

    // From EXEC: apply one select for one cycle, then return to STALL
    task automatic redirect(input logic [2:0] sel, input logic [31:0] off, input logic [31:0] alu);
        pc_next_sel_i = sel;
        pc_next_off_i = off;
        alu_res_i     = alu;
        step();
        pc_next_sel_i = PC_NEXT_SEL_STALL;
        pc_next_off_i = 32'h0;
        alu_res_i     = 32'h0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({imem_req_o, instr_valid_o, misalign_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got req/valid/mis=%b expected 000", {imem_req_o, instr_valid_o, misalign_o});
        end
        vectors++;
        if (pc_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_pc: got %h expected 00000000", pc_o);
        end
        vectors++;
        if (pc_data_o !== NOP) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected %h", pc_data_o, NOP);
        end
    endtask

    task automatic test_first_fetch();
        step();
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req_o, imem_addr_o);
        end
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        vectors++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_state: got req=%b valid=%b expected 0 0", imem_req_o, instr_valid_o);
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0050_0093;
        step();
        imem_rvalid_i = 1'b0;
        vectors++;
        if (pc_data_o !== 32'h0050_0093 || instr_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL first_data: got %h valid=%b expected 00500093 valid=1", pc_data_o, instr_valid_o);
        end
        pc_isize_i = 3'd4;
        redirect(PC_NEXT_SEL_NEXT, 32'h0, 32'h0);
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || instr_valid_o !== 1'b0 || pc_data_o !== NOP) begin
            miscompares++;
            $display("FAIL next_seq: got req=%b addr=%h valid=%b data=%h expected 1 00000004 0 %h",
                     imem_req_o, imem_addr_o, instr_valid_o, pc_data_o, NOP);
        end
    endtask

    task automatic test_branches();
        do_fetch(32'h1111_1111);
        redirect(PC_NEXT_SEL_PC_IMM, 32'h0000_000C, 32'h0);   // 4 + 0xC = 0x10
        do_fetch(32'h2222_2222);
        vectors++;
        if (pc_o !== 32'h10 || pc_data_o !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL pc_imm_fwd: got pc=%h data=%h expected 00000010 22222222", pc_o, pc_data_o);
        end
        redirect(PC_NEXT_SEL_PC_IMM, 32'hFFFF_FFF8, 32'h0);
        vectors++;
        if (imem_addr_o !== 32'h8) begin
            miscompares++;
            $display("FAIL pc_imm_back: got %h expected 00000008", imem_addr_o);
        end
        do_fetch(32'h3333_3333);
        redirect(PC_NEXT_SEL_COND_PC_IMM, 32'h20, 32'h0);
        vectors++;
        if (imem_addr_o !== 32'hC) begin
            miscompares++;
            $display("FAIL cond_not_taken: got %h expected 0000000c", imem_addr_o);
        end
        do_fetch(32'h4444_4444);
        redirect(PC_NEXT_SEL_PC_IMM, 32'hFFFF_FFFC, 32'h0);   // back to 0x08
        do_fetch(32'h5555_5555);
        redirect(PC_NEXT_SEL_COND_PC_IMM, 32'h20, 32'hFFFF_FFFF);
        vectors++;
        if (imem_addr_o !== 32'h28) begin
            miscompares++;
            $display("FAIL cond_taken: got %h expected 00000028", imem_addr_o);
        end
    endtask

    task automatic test_jump_and_stall();
        do_fetch(32'h6666_6666);
        rs1_data_i = 32'h0000_1001;
        redirect(PC_NEXT_SEL_RS1_IMM, 32'h4, 32'h0);
        rs1_data_i = 32'h0;
        vectors++;
        if (pc_o !== 32'h1004 || imem_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rs1_imm: got pc=%h req=%b expected 00001004 1", pc_o, imem_req_o);
        end
        do_fetch(32'h7777_7777);
        pc_next_sel_i = PC_NEXT_SEL_STALL;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (pc_o !== 32'h1004 || pc_data_o !== 32'h7777_7777 || instr_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got pc=%h data=%h valid=%b req=%b expected 00001004 77777777 1 0",
                         i, pc_o, pc_data_o, instr_valid_o, imem_req_o);
            end
        end
        pc_next_sel_i = 3'd6;   // unused encoding behaves as STALL
        step();
        step();
        pc_next_sel_i = PC_NEXT_SEL_STALL;
        vectors++;
        if (pc_o !== 32'h1004 || instr_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL unused_sel: got pc=%h valid=%b req=%b expected 00001004 1 0", pc_o, instr_valid_o, imem_req_o);
        end
    endtask

    task automatic test_ready_stall();
        int t_req;
        int t_exec;
        redirect(PC_NEXT_SEL_NEXT, 32'h0, 32'h0);   // 0x1004 + 4
        t_req = cyc;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) imem_ready_i = 1'b1;
            vectors++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1008) begin
                miscompares++;
                $display("FAIL req_hold[%0d]: got req=%b addr=%h expected 1 00001008", i, imem_req_o, imem_addr_o);
            end
            step();
        end
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h8888_8888;
        step();
        imem_rvalid_i = 1'b0;
        t_exec = cyc;
        vectors++;
        if (instr_valid_o !== 1'b1 || pc_data_o !== 32'h8888_8888 || (t_exec - t_req) !== 6) begin
            miscompares++;
            $display("FAIL ready_latency: got valid=%b data=%h cycles=%0d expected 1 88888888 6",
                     instr_valid_o, pc_data_o, t_exec - t_req);
        end
    endtask

    task automatic test_misalign();
        apply_reset();
        step();
        do_fetch(32'h9999_9999);
        redirect(PC_NEXT_SEL_PC_IMM, 32'h6, 32'h0);
        pc_next_sel_i = PC_NEXT_SEL_NEXT;
        imem_ready_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (misalign_o !== 1'b1 || pc_o !== 32'h0 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || pc_data_o !== NOP) begin
                miscompares++;
                $display("FAIL trap[%0d]: got mis=%b pc=%h req=%b valid=%b data=%h expected 1 00000000 0 0 %h",
                         i, misalign_o, pc_o, imem_req_o, instr_valid_o, pc_data_o, NOP);
            end
            step();
        end
        pc_next_sel_i = PC_NEXT_SEL_STALL;
        imem_ready_i  = 1'b0;
        apply_reset();
        vectors++;
        if (misalign_o !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_clear: got %b expected 0", misalign_o);
        end
        step();
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL trap_restart: got req=%b addr=%h expected 1 00000000", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_reset_in_wait();
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i         = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        step();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        vectors++;
        if (instr_valid_o !== 1'b0 || pc_data_o !== NOP || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL stale_rvalid: got valid=%b data=%h req=%b addr=%h expected 0 %h 1 00000000",
                     instr_valid_o, pc_data_o, imem_req_o, imem_addr_o, NOP);
        end
        do_fetch(32'hA5A5_0013);
        vectors++;
        if (instr_valid_o !== 1'b1 || pc_data_o !== 32'hA5A5_0013) begin
            miscompares++;
            $display("FAIL post_reset_fetch: got valid=%b data=%h expected 1 a5a50013", instr_valid_o, pc_data_o);
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        pc_next_sel_i = PC_NEXT_SEL_STALL;
        pc_next_off_i = 32'h0;
        pc_isize_i    = 3'd4;
        rs1_data_i    = 32'h0;
        alu_res_i     = 32'h0;
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        test_reset();
        test_first_fetch();
        test_branches();
        test_jump_and_stall();
        test_ready_stall();
        test_misalign();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
